// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: default bus geometry and the master adapter FSM states.
package wishbone_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wishbone_if.sv
// Classic single-cycle Wishbone bus bundle with master and slave views.
interface wishbone_if #(
  parameter int unsigned addr_width   = wishbone_pkg::WB_ADDR_W,
  parameter int unsigned data_width   = wishbone_pkg::WB_DATA_W,
  parameter int unsigned strobe_width = wishbone_pkg::WB_SEL_W
) ();

  logic [addr_width-1:0]   wb_adr;
  logic [data_width-1:0]   wb_datwr;
  logic [data_width-1:0]   wb_datrd;
  logic                    wb_we;
  logic                    wb_stb;
  logic                    wb_cyc;
  logic [strobe_width-1:0] wb_sel;
  logic                    wb_ack;

  modport master (
    output wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
    input  wb_datrd, wb_ack
  );

  modport slave (
    input  wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel,
    output wb_datrd, wb_ack
  );

endinterface

// File: rtl/wb_timeout_counter.sv
// Counts bus cycles of the current transfer; expired is high during the cycle in
// which the count equals TIMEOUT, so an abort lands exactly TIMEOUT cycles after entry.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit              ENABLED = (TIMEOUT != 0);
  localparam int unsigned     CW      = ENABLED ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   LIMIT   = CW'(TIMEOUT);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          expired_d;

  // Clear loads 1 because the entry cycle itself is the first counted bus cycle.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = CW'(1);
    end else if (ENABLED && enable && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
    expired_d = ENABLED && (count_d == LIMIT);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      expired <= 1'b0;
    end else begin
      count_q <= count_d;
      expired <= expired_d;
    end
  end

endmodule

// File: rtl/wb_master_adapter.sv
// Converts a valid/ready request/response core interface into single Wishbone
// classic cycles, one outstanding transfer at a time, with an optional timeout.
module wb_master_adapter
  import wishbone_pkg::*;
#(
  parameter int unsigned addr_width   = WB_ADDR_W,
  parameter int unsigned data_width   = WB_DATA_W,
  parameter int unsigned strobe_width = WB_SEL_W,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [data_width-1:0]   req_data,
  input  logic                    req_we,
  input  logic [strobe_width-1:0] req_sel,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [data_width-1:0]   resp_data,
  output logic                    resp_err,
  wishbone_if.master              wb
);

  wb_state_e               state_q;
  wb_state_e               state_d;
  logic                    req_ready_d;
  logic                    resp_valid_d;
  logic [data_width-1:0]   resp_data_d;
  logic                    resp_err_d;
  logic                    cyc_q;
  logic                    cyc_d;
  logic                    stb_q;
  logic                    stb_d;
  logic                    we_q;
  logic                    we_d;
  logic [addr_width-1:0]   adr_q;
  logic [addr_width-1:0]   adr_d;
  logic [data_width-1:0]   datwr_q;
  logic [data_width-1:0]   datwr_d;
  logic [strobe_width-1:0] sel_q;
  logic [strobe_width-1:0] sel_d;
  logic                    tmo_clear_c;
  logic                    tmo_enable_c;
  logic                    tmo_expired;

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (tmo_clear_c),
    .enable  (tmo_enable_c),
    .expired (tmo_expired)
  );

  // Next-state and next-register values; the bus registers double as the request latch.
  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready;
    resp_valid_d = resp_valid;
    resp_data_d  = resp_data;
    resp_err_d   = resp_err;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    we_d         = we_q;
    adr_d        = adr_q;
    datwr_d      = datwr_q;
    sel_d        = sel_q;
    tmo_clear_c  = 1'b0;
    tmo_enable_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_d     = BUS;
          req_ready_d = 1'b0;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          we_d        = req_we;
          adr_d       = req_addr;
          datwr_d     = req_data;
          sel_d       = req_sel;
          tmo_clear_c = 1'b1;
        end
      end

      BUS: begin
        // Ack is checked first so a coincident ack beats the timeout.
        if (wb.wb_ack) begin
          state_d      = RESP;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_data_d  = we_q ? '0 : wb.wb_datrd;
        end else if (tmo_expired) begin
          state_d      = RESP;
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_data_d  = '0;
        end else begin
          tmo_enable_c = 1'b1;
        end
      end

      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d      = IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
        cyc_d        = 1'b0;
        stb_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      datwr_q    <= '0;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_data  <= resp_data_d;
      resp_err   <= resp_err_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      datwr_q    <= datwr_d;
      sel_q      <= sel_d;
    end
  end

  assign wb.wb_cyc   = cyc_q;
  assign wb.wb_stb   = stb_q;
  assign wb.wb_we    = we_q;
  assign wb.wb_adr   = adr_q;
  assign wb.wb_datwr = datwr_q;
  assign wb.wb_sel   = sel_q;

endmodule

// File: tb/tb_wb_master_adapter.sv
// Directed bench for wb_master_adapter: scoreboarded responses from a TIMEOUT=8
// instance plus a TIMEOUT=4 instance for the ack/timeout race.
module tb_wb_master_adapter;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        clock;
  logic        reset;

  logic        req_valid,   req_ready,   req_we,   resp_valid,   resp_ready,   resp_err;
  logic [31:0] req_addr,    req_data,    resp_data;
  logic [3:0]  req_sel;
  logic        req_valid_4, req_ready_4, req_we_4, resp_valid_4, resp_ready_4, resp_err_4;
  logic [31:0] req_addr_4,  req_data_4,  resp_data_4;
  logic [3:0]  req_sel_4;

  wishbone_if #(.addr_width(32), .data_width(32), .strobe_width(4)) wb8 ();
  wishbone_if #(.addr_width(32), .data_width(32), .strobe_width(4)) wb4 ();

  wb_master_adapter #(
    .addr_width(32), .data_width(32), .strobe_width(4), .TIMEOUT(8)
  ) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_we(req_we), .req_sel(req_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_err(resp_err), .wb(wb8.master)
  );

  wb_master_adapter #(
    .addr_width(32), .data_width(32), .strobe_width(4), .TIMEOUT(4)
  ) u_dut4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_4), .req_ready(req_ready_4), .req_addr(req_addr_4),
    .req_data(req_data_4), .req_we(req_we_4), .req_sel(req_sel_4),
    .resp_valid(resp_valid_4), .resp_ready(resp_ready_4), .resp_data(resp_data_4),
    .resp_err(resp_err_4), .wb(wb4.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_exp(input string tag, output exp_t e);
    check1({tag, "_sb_nonempty"}, sb.size() != 0, 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
    end else begin
      e.data = 'x;
      e.err  = 1'bx;
    end
  endtask

  // Drive one request on the TIMEOUT=8 instance; returns in the first BUS cycle.
  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic we,
                       input logic [3:0] s, input logic [31:0] ed, input logic ee);
    exp_t e;
    check1("issue_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_we    = we;
    req_sel   = s;
    e.data    = ed;
    e.err     = ee;
    sb.push_back(e);
    tick();
    req_valid = 1'b0;
    check1("issue_busy", req_ready, 1'b0);
  endtask

  // Compare the pending response with the scoreboard head, then hand it off.
  task automatic take_resp(input string tag);
    exp_t e;
    check1({tag, "_valid"}, resp_valid, 1'b1);
    pop_exp(tag, e);
    check32({tag, "_data"}, resp_data, e.data);
    check1({tag, "_err"}, resp_err, e.err);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check1({tag, "_valid_drop"}, resp_valid, 1'b0);
    check1({tag, "_idle_ready"}, req_ready, 1'b1);
  endtask

  initial begin
    exp_t e;
    int   n;

    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_we = 1'b0; req_sel = '0;
    resp_ready = 1'b0;
    req_valid_4 = 1'b0; req_addr_4 = '0; req_data_4 = '0; req_we_4 = 1'b0; req_sel_4 = '0;
    resp_ready_4 = 1'b0;
    wb8.wb_ack = 1'b0; wb8.wb_datrd = '0;
    wb4.wb_ack = 1'b0; wb4.wb_datrd = '0;

    // Reset values before any clock edge
    #2 reset = 1'b0;
    #2;
    check1("rst_req_ready", req_ready, 1'b1);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check1("rst_resp_err", resp_err, 1'b0);
    check32("rst_resp_data", resp_data, 32'h0);
    check1("rst_cyc", wb8.wb_cyc, 1'b0);
    check1("rst_stb", wb8.wb_stb, 1'b0);
    check1("rst_we", wb8.wb_we, 1'b0);
    check32("rst_adr", wb8.wb_adr, 32'h0);
    check32("rst_datwr", wb8.wb_datwr, 32'h0);
    check32("rst_sel", 32'(wb8.wb_sel), 32'h0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Spurious ack while idle
    wb8.wb_ack = 1'b1; wb8.wb_datrd = 32'hBAD0_BAD0;
    wb4.wb_ack = 1'b1; wb4.wb_datrd = 32'hBAD0_BAD0;
    tick();
    tick();
    check1("spur_resp_valid", resp_valid, 1'b0);
    check1("spur_req_ready", req_ready, 1'b1);
    check1("spur_cyc", wb8.wb_cyc, 1'b0);
    check32("spur_resp_data", resp_data, 32'h0);
    check1("spur4_resp_valid", resp_valid_4, 1'b0);
    wb8.wb_ack = 1'b0; wb8.wb_datrd = '0;
    wb4.wb_ack = 1'b0; wb4.wb_datrd = '0;

    // Zero-wait read
    issue(32'h100, 32'h0, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0);
    check1("rd0_cyc", wb8.wb_cyc, 1'b1);
    check1("rd0_stb", wb8.wb_stb, 1'b1);
    check32("rd0_adr", wb8.wb_adr, 32'h100);
    check1("rd0_we", wb8.wb_we, 1'b0);
    check1("rd0_no_early_resp", resp_valid, 1'b0);
    wb8.wb_ack = 1'b1; wb8.wb_datrd = 32'hDEAD_BEEF;
    tick();
    wb8.wb_ack = 1'b0; wb8.wb_datrd = '0;
    check1("rd0_cyc_drop", wb8.wb_cyc, 1'b0);
    take_resp("rd0");

    // Write with three wait states
    issue(32'h20, 32'h1234_5678, 1'b1, 4'h3, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check1("wr3_cyc", wb8.wb_cyc, 1'b1);
      check32("wr3_adr", wb8.wb_adr, 32'h20);
      check32("wr3_datwr", wb8.wb_datwr, 32'h1234_5678);
      check32("wr3_sel", 32'(wb8.wb_sel), 32'h3);
      check1("wr3_we", wb8.wb_we, 1'b1);
      check1("wr3_no_early_resp", resp_valid, 1'b0);
      if (k == 3) begin
        wb8.wb_ack = 1'b1; wb8.wb_datrd = 32'hFFFF_FFFF;
      end
      tick();
    end
    wb8.wb_ack = 1'b0; wb8.wb_datrd = '0;
    take_resp("wr3");

    // Timeout with a silent slave, then a normal request
    wb8.wb_datrd = 32'h5555_5555;
    issue(32'h40, 32'h0, 1'b0, 4'hF, 32'h0, 1'b1);
    n = 0;
    while (wb8.wb_cyc && n < 20) begin
      n++;
      tick();
    end
    check32("tmo_bus_cycles", 32'(n), 32'd8);
    take_resp("tmo");
    issue(32'h44, 32'h0, 1'b0, 4'hF, 32'hCAFE_F00D, 1'b0);
    check32("post_tmo_adr", wb8.wb_adr, 32'h44);
    wb8.wb_ack = 1'b1; wb8.wb_datrd = 32'hCAFE_F00D;
    tick();
    wb8.wb_ack = 1'b0; wb8.wb_datrd = '0;
    take_resp("post_tmo");

    // Response backpressure with a zero-select write waiting behind it
    issue(32'h80, 32'h0, 1'b0, 4'hF, 32'hA5A5_5A5A, 1'b0);
    wb8.wb_ack = 1'b1; wb8.wb_datrd = 32'hA5A5_5A5A;
    tick();
    wb8.wb_ack = 1'b0; wb8.wb_datrd = '0;
    req_valid = 1'b1; req_addr = 32'h84; req_data = 32'h0BAD_CAFE; req_we = 1'b1; req_sel = 4'h0;
    e.data = 32'h0; e.err = 1'b0;
    sb.push_back(e);
    for (int k = 0; k < 6; k++) begin
      check1("bp_resp_valid", resp_valid, 1'b1);
      check32("bp_resp_data", resp_data, 32'hA5A5_5A5A);
      check1("bp_req_ready", req_ready, 1'b0);
      check1("bp_cyc", wb8.wb_cyc, 1'b0);
      tick();
    end
    take_resp("bp");
    tick();
    req_valid = 1'b0;
    check1("b2b_cyc", wb8.wb_cyc, 1'b1);
    check32("b2b_adr", wb8.wb_adr, 32'h84);
    check32("b2b_datwr", wb8.wb_datwr, 32'h0BAD_CAFE);
    check32("b2b_sel", 32'(wb8.wb_sel), 32'h0);
    check1("b2b_we", wb8.wb_we, 1'b1);
    wb8.wb_ack = 1'b1;
    tick();
    wb8.wb_ack = 1'b0;
    take_resp("sel0_wr");

    // Reset in the second bus cycle
    issue(32'h200, 32'h1111_2222, 1'b1, 4'hF, 32'h0, 1'b0);
    tick();
    check1("mid_rst_cyc_before", wb8.wb_cyc, 1'b1);
    #2 reset = 1'b0;
    #1;
    check1("mid_rst_cyc", wb8.wb_cyc, 1'b0);
    check1("mid_rst_stb", wb8.wb_stb, 1'b0);
    check1("mid_rst_req_ready", req_ready, 1'b1);
    check1("mid_rst_resp_valid", resp_valid, 1'b0);
    void'(sb.pop_back());
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check1("post_rst_resp_valid", resp_valid, 1'b0);
      check1("post_rst_req_ready", req_ready, 1'b1);
      check1("post_rst_cyc", wb8.wb_cyc, 1'b0);
    end

    // TIMEOUT=4: ack lands in the same cycle the timeout expires
    check1("t4_ready", req_ready_4, 1'b1);
    req_valid_4 = 1'b1; req_addr_4 = 32'h300; req_we_4 = 1'b0; req_sel_4 = 4'hF;
    e.data = 32'h600D_F00D; e.err = 1'b0;
    sb.push_back(e);
    tick();
    req_valid_4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check1("t4_race_cyc", wb4.wb_cyc, 1'b1);
      if (k == 3) begin
        wb4.wb_ack = 1'b1; wb4.wb_datrd = 32'h600D_F00D;
      end
      tick();
    end
    wb4.wb_ack = 1'b0; wb4.wb_datrd = 32'h7777_7777;
    check1("t4_race_valid", resp_valid_4, 1'b1);
    pop_exp("t4_race", e);
    check32("t4_race_data", resp_data_4, e.data);
    check1("t4_race_err", resp_err_4, e.err);
    resp_ready_4 = 1'b1;
    tick();
    resp_ready_4 = 1'b0;
    check1("t4_race_idle", req_ready_4, 1'b1);

    // TIMEOUT=4 with no ack at all
    req_valid_4 = 1'b1; req_addr_4 = 32'h304;
    e.data = 32'h0; e.err = 1'b1;
    sb.push_back(e);
    tick();
    req_valid_4 = 1'b0;
    n = 0;
    while (wb4.wb_cyc && n < 20) begin
      n++;
      tick();
    end
    check32("t4_tmo_bus_cycles", 32'(n), 32'd4);
    check1("t4_tmo_valid", resp_valid_4, 1'b1);
    pop_exp("t4_tmo", e);
    check32("t4_tmo_data", resp_data_4, e.data);
    check1("t4_tmo_err", resp_err_4, e.err);
    resp_ready_4 = 1'b1;
    tick();
    resp_ready_4 = 1'b0;
    check1("t4_tmo_idle", req_ready_4, 1'b1);

    check32("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_master_adapter.md
WB_MASTER_ADAPTER -- requirements
Module: wb_master_adapter

Interface
REQ-001 Parameters SHALL be, one per line:
- addr_width, 32, address width
- data_width, 32, data width
- strobe_width, 4, byte-select width
- TIMEOUT, 255, bus cycles without ack before abort (0 = disabled)
REQ-002 Ports SHALL be, one per line:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  core request valid
- req_ready  out  1  adapter accepts request
- req_addr  in  addr_width  request address
- req_data  in  data_width  write data
- req_we  in  1  1 = write, 0 = read
- req_sel  in  strobe_width  byte selects
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_data  out  data_width  read data (0 for writes/errors)
- resp_err  out  1  transaction timed out
- wb_adr, wb_datwr, wb_we, wb_stb, wb_cyc, wb_sel  out  per Wishbone master modport  Wishbone master side
- wb_datrd, wb_ack  in  per Wishbone master modport  slave return
REQ-003 The Wishbone side SHALL connect to the wishbone interface through its master modport, with identical parameter values.

Function
REQ-004 The FSM SHALL have three states: IDLE, BUS, RESP.
REQ-005 IDLE: req_ready=1; on req_valid&&req_ready, latch addr/data/we/sel into registers and go to BUS.
REQ-006 req_ready SHALL be 0 in BUS and RESP: one outstanding transaction maximum.
REQ-007 BUS: wb_cyc=wb_stb=1, and wb_adr/wb_datwr/wb_we/wb_sel SHALL hold the latched values and stay stable until ack or abort.
REQ-008 All wb_* outputs SHALL be registered: cyc/stb assert in the cycle after request acceptance.
REQ-009 BUS with wb_ack=1 at a rising edge:
- capture wb_datrd into resp_data for reads; resp_data=0 for writes
- resp_err=0
- deassert cyc/stb on that same edge
- go to RESP
REQ-010 The timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-011 When the counter reaches TIMEOUT with no ack: deassert cyc/stb, resp_data=0, resp_err=1, go to RESP.
REQ-012 Ack and timeout on the same edge: ack SHALL win (resp_err=0).
REQ-013 With TIMEOUT=0 the counter SHALL be disabled; BUS waits indefinitely.
REQ-014 The counter width SHALL be $clog2(TIMEOUT+1), with no wrap before the compare.
REQ-015 RESP: resp_valid=1, with resp_data/resp_err stable until resp_valid&&resp_ready; then go to IDLE.
REQ-016 Latency: with a zero-wait slave, resp_valid SHALL assert 2 cycles after request acceptance; each slave wait state adds 1 cycle.
REQ-017 Back-to-back: a new request SHALL be acceptable in the cycle after the response handshake.
REQ-018 wb_ack outside BUS SHALL be ignored; it causes no state change and no data capture.
REQ-019 req_sel=0 writes SHALL still be issued on the bus unchanged.

Reset
REQ-020 While reset=0, the block SHALL asynchronously force:
- state IDLE
- req_ready=1
- resp_valid=0, resp_err=0, resp_data=0
- wb_cyc=wb_stb=wb_we=0, wb_adr=wb_datwr=wb_sel=0
- counter cleared
REQ-021 Reset mid-transaction SHALL drop cyc/stb immediately; the aborted transaction SHALL produce no response after reset release.

Structure
REQ-022 The FSM state enum typedef (IDLE/BUS/RESP) SHALL live in wishbone_pkg, alongside the interface.
REQ-023 The timeout counter SHALL be one sub-module, wb_timeout_counter (clear, enable, expired output; parameter TIMEOUT).

Verification
REQ-024 Zero-wait read: req addr 0x100; slave acks in the first BUS cycle with 0xDEADBEEF -> resp_valid 2 cycles after accept, resp_data=0xDEADBEEF, resp_err=0.
REQ-025 Write with 3 wait states: addr 0x20, data 0x12345678, sel 0x3 -> wb_adr/datwr/sel/we stable for 4 BUS cycles, resp_valid 5 cycles after accept, resp_data=0.
REQ-026 Timeout: TIMEOUT=8, slave never acks -> cyc drops after 8 BUS cycles, resp_err=1, resp_data=0; next request accepted normally.
REQ-027 Response backpressure: resp_ready held 0 for 6 cycles -> resp_valid and resp_data stable, req_ready=0 throughout; IDLE the cycle after the handshake.
REQ-028 Reset asserted in the second BUS cycle -> cyc/stb=0 with no clock edge; after release, no resp_valid and req_ready=1.
REQ-029 Spurious wb_ack in IDLE, plus ack coincident with timeout (TIMEOUT=4, ack on the 4th cycle) -> ack in IDLE ignored; coincident case returns resp_err=0 with the slave data.
